uart_tx_serializer: RTL and testbench

Byte-wide transmit serializer that sits directly downstream of the memory-mapped UART slave on the core's AXI-lite crossbar. The UART slave hands it each byte written to the TX data register. The block buffers bytes in a small FIFO and shifts each one out as an 8N1 frame on a single `tx` line at a parameterised bit period. It reports backpressure, activity and overflow so the UART slave can expose status to software.

---
 rtl/uart_tx_serializer.sv | 147 ++++++++++++++
 tb/tb_uart_tx_serializer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// Byte-wide 8N1 transmit serializer fed from a small FIFO.
// One frame is start bit, eight data bits LSB first, and one stop bit, with each bit lasting DIV clocks.
module uart_tx_serializer #(
  parameter int DIV        = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  input  logic                          clr_err,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  state_t        state;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [DW-1:0] div_cnt;
  logic          bit_done;
  logic          push;
  logic          pop;

  // Full-ness comes only from the registered count, so a same-cycle pop never frees a slot.
  assign wr_ready   = (count != FULL_COUNT);
  assign push       = wr_valid && wr_ready;
  assign bit_done   = (div_cnt == DIV_LAST);
  assign pop        = (count != '0) && ((state == IDLE) || (state == STOP && bit_done));
  assign fifo_count = count;
  assign busy       = (count != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + AW'(1);
      end
      if (pop) begin
        head <= head + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // If a refused write and a clear arrive in the same cycle, the error stays set.
      if (wr_valid && !wr_ready) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shift   <= '0;
      bit_idx <= '0;
      div_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          div_cnt <= '0;
          if (pop) begin
            shift <= mem[head];
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_done) begin
            div_cnt <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            div_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        STOP: begin
          if (bit_done) begin
            div_cnt <= '0;
            // A queued byte starts its start bit right after the stop bit, with no idle gap.
            if (pop) begin
              shift <= mem[head];
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer: random and directed stimulus checked against a frame-level model.
// A separate line decoder turns tx back into bytes, so the bench can check delivery order.
module tb_uart_tx_serializer;

  localparam int DIV   = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       clr_err;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_count;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  uart_tx_serializer #(.DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_err(clr_err), .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // The model treats each frame as a 10-bit word, {stop, data, start}, that takes 10*DIV cycles to send.
  logic [7:0] m_q[$];
  logic [7:0] m_acc[$];
  logic [9:0] m_frame = '0;
  int         m_left = 0;
  int         m_el = 0;
  logic       m_ovf = 1'b0;
  bit         m_ready;
  bit         m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_left = 0;
      m_el   = 0;
      m_ovf  = 1'b0;
    end else begin
      m_ready = (m_q.size() != DEPTH);
      m_pop   = (m_q.size() > 0) && (m_left <= 1);
      if (wr_valid && !m_ready) m_ovf = 1'b1;
      else if (clr_err) m_ovf = 1'b0;
      if (m_pop) begin
        m_frame = {1'b1, m_q.pop_front(), 1'b0};
        m_left  = 10 * DIV;
        m_el    = 0;
      end else if (m_left > 0) begin
        m_left--;
        m_el++;
      end
      if (wr_valid && m_ready) begin
        m_q.push_back(wr_data);
        m_acc.push_back(wr_data);
      end
    end
  end

  function automatic logic exp_tx();
    return (m_left > 0) ? m_frame[m_el / DIV] : 1'b1;
  endfunction

  function automatic logic exp_busy();
    return (m_left > 0) || (m_q.size() > 0);
  endfunction

  // The line decoder samples each bit in the middle of its period.
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte = '0;
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  int         rx_err = 0;
  int         rx_idx;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      rx_act = 1'b0;
      rx_cnt = 0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= DIV / 2 && ((rx_cnt - DIV / 2) % DIV) == 0) begin
        rx_idx = (rx_cnt - DIV / 2) / DIV;
        if (rx_idx >= 1 && rx_idx <= 8) rx_byte[rx_idx-1] = tx;
        if (rx_idx == 9) begin
          if (tx !== 1'b1) rx_err++;
          rx_q.push_back(rx_byte);
          rx_act = 1'b0;
        end
      end
    end
  end

  task automatic tick(input logic v, input logic [7:0] d, input logic c);
    wr_valid = v;
    wr_data  = d;
    clr_err  = c;
    @(negedge clk);
    wr_valid = 1'b0;
    clr_err  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_valid = 1'b0;
    wr_data = '0;
    clr_err = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx got=%b exp=1", tx); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", wr_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int fall_at = -1;
    m_acc.delete();
    rx_q.delete();
    tick(1'b1, 8'h55, 1'b0);
    checks++; if (fifo_count !== 4'd1) begin failures++; $display("[TB] FAIL single_count_push got=%0d exp=1", fifo_count); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy_rise got=%b exp=1", busy); end
    for (int k = 1; k <= 50; k++) begin
      tick(1'b0, 8'h00, 1'b0);
      if (k == 1) begin
        checks++; if (fifo_count !== 4'd0) begin failures++; $display("[TB] FAIL single_count_pop got=%0d exp=0", fifo_count); end
      end
      checks++; if (tx !== exp_tx()) begin failures++; $display("[TB] FAIL single_tx cyc=%0d got=%b exp=%b", k, tx, exp_tx()); end
      if (busy === 1'b0 && fall_at < 0) fall_at = k;
    end
    checks++; if (fall_at != 10 * DIV + 1) begin failures++; $display("[TB] FAIL single_busy_fall got=%0d exp=%0d", fall_at, 10 * DIV + 1); end
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
      failures++; $display("[TB] FAIL single_rx got_n=%0d exp_n=1", rx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3] = '{8'hA5, 8'h00, 8'hFF};
    int busy_cycles = 0;
    m_acc.delete();
    rx_q.delete();
    for (int i = 0; i < 3; i++) tick(1'b1, bytes[i], 1'b0);
    for (int k = 1; k <= 130; k++) begin
      tick(1'b0, 8'h00, 1'b0);
      checks++; if (tx !== exp_tx()) begin failures++; $display("[TB] FAIL b2b_tx cyc=%0d got=%b exp=%b", k, tx, exp_tx()); end
      checks++; if (busy !== exp_busy()) begin failures++; $display("[TB] FAIL b2b_busy cyc=%0d got=%b exp=%b", k, busy, exp_busy()); end
      if (busy === 1'b1) busy_cycles++;
    end
    checks++; if (busy_cycles != 30 * DIV - 2) begin failures++; $display("[TB] FAIL b2b_busy_len got=%0d exp=%0d", busy_cycles, 30 * DIV - 2); end
    checks++; if (rx_q.size() != 3) begin failures++; $display("[TB] FAIL b2b_rx_n got=%0d exp=3", rx_q.size()); end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== bytes[i]) begin failures++; $display("[TB] FAIL b2b_rx[%0d] got=%h exp=%h", i, rx_q[i], bytes[i]); end
    end
  endtask

  task automatic test_overflow();
    m_acc.delete();
    rx_q.delete();
    for (int i = 0; i < 10; i++) begin
      checks++; if (wr_ready !== (i < 9)) begin failures++; $display("[TB] FAIL ovf_ready push=%0d got=%b exp=%b", i, wr_ready, (i < 9)); end
      if (i == 9) begin
        checks++; if (fifo_count !== 4'd8) begin failures++; $display("[TB] FAIL ovf_count got=%0d exp=8", fifo_count); end
      end
      tick(1'b1, 8'($urandom), 1'b0);
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("[TB] FAIL ovf_still_full got=%b exp=0", wr_ready); end
    tick(1'b1, 8'hEE, 1'b1);
    checks++; if (overflow !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set_wins got=%b exp=1", overflow); end
    tick(1'b0, 8'h00, 1'b1);
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL ovf_clear got=%b exp=0", overflow); end
    for (int k = 0; k < 500 && busy === 1'b1; k++) begin
      tick(1'b0, 8'h00, 1'b0);
      checks++; if (tx !== exp_tx()) begin failures++; $display("[TB] FAIL ovf_tx cyc=%0d got=%b exp=%b", k, tx, exp_tx()); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL ovf_drain_timeout got=%b exp=0", busy); end
    checks++; if (rx_q.size() != 9) begin failures++; $display("[TB] FAIL ovf_frames got=%0d exp=9", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < m_acc.size(); i++) begin
      checks++; if (rx_q[i] !== m_acc[i]) begin failures++; $display("[TB] FAIL ovf_rx[%0d] got=%h exp=%h", i, rx_q[i], m_acc[i]); end
    end
  endtask

  task automatic test_reset_mid();
    m_acc.delete();
    rx_q.delete();
    tick(1'b1, 8'h11, 1'b0);
    tick(1'b1, 8'h22, 1'b0);
    tick(1'b1, 8'h33, 1'b0);
    // Advance into data bit 3 of the first frame.
    repeat (4 * DIV) tick(1'b0, 8'h00, 1'b0);
    checks++; if (fifo_count !== 4'd2) begin failures++; $display("[TB] FAIL mid_queued got=%0d exp=2", fifo_count); end
    checks++; if (tx !== exp_tx()) begin failures++; $display("[TB] FAIL mid_tx_pre got=%b exp=%b", tx, exp_tx()); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin failures++; $display("[TB] FAIL mid_tx_async got=%b exp=1", tx); end
    checks++; if (fifo_count !== 4'd0) begin failures++; $display("[TB] FAIL mid_count got=%0d exp=0", fifo_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    for (int k = 0; k < 60; k++) begin
      tick(1'b0, 8'h00, 1'b0);
      checks++; if (tx !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_quiet cyc=%0d tx=%b busy=%b exp tx=1 busy=0", k, tx, busy); end
    end
    checks++; if (rx_q.size() != 0) begin failures++; $display("[TB] FAIL mid_no_frame got=%0d exp=0", rx_q.size()); end
    tick(1'b1, 8'h3C, 1'b0);
    repeat (10 * DIV + 4) tick(1'b0, 8'h00, 1'b0);
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
      failures++; $display("[TB] FAIL mid_new_frame got_n=%0d exp_n=1", rx_q.size());
    end
  endtask

  task automatic test_wrap();
    int sent = 0;
    m_acc.delete();
    rx_q.delete();
    for (int k = 0; k < 2000 && (sent < 20 || busy === 1'b1); k++) begin
      if (sent < 20 && wr_ready === 1'b1) begin
        tick(1'b1, 8'(sent), 1'b0);
        sent++;
      end else begin
        tick(1'b0, 8'h00, 1'b0);
      end
      checks++; if (tx !== exp_tx()) begin failures++; $display("[TB] FAIL wrap_tx cyc=%0d got=%b exp=%b", k, tx, exp_tx()); end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL wrap_timeout got=%b exp=0", busy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("[TB] FAIL wrap_ovf got=%b exp=0", overflow); end
    checks++; if (rx_q.size() != 20) begin failures++; $display("[TB] FAIL wrap_rx_n got=%0d exp=20", rx_q.size()); end
    for (int i = 0; i < rx_q.size(); i++) begin
      checks++; if (rx_q[i] !== 8'(i)) begin failures++; $display("[TB] FAIL wrap_rx[%0d] got=%h exp=%h", i, rx_q[i], 8'(i)); end
    end
  endtask

  task automatic test_random();
    m_acc.delete();
    rx_q.delete();
    for (int k = 0; k < 800; k++) begin
      tick(1'($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom_range(0, 30) == 0));
      checks++; if (tx !== exp_tx()) begin failures++; $display("[TB] FAIL rnd_tx cyc=%0d got=%b exp=%b", k, tx, exp_tx()); end
      checks++; if (busy !== exp_busy()) begin failures++; $display("[TB] FAIL rnd_busy cyc=%0d got=%b exp=%b", k, busy, exp_busy()); end
      checks++; if (fifo_count !== 4'(m_q.size())) begin failures++; $display("[TB] FAIL rnd_count cyc=%0d got=%0d exp=%0d", k, fifo_count, m_q.size()); end
      checks++; if (overflow !== m_ovf) begin failures++; $display("[TB] FAIL rnd_ovf cyc=%0d got=%b exp=%b", k, overflow, m_ovf); end
      checks++; if (wr_ready !== (m_q.size() != DEPTH)) begin failures++; $display("[TB] FAIL rnd_ready cyc=%0d got=%b", k, wr_ready); end
    end
    for (int k = 0; k < 600 && busy === 1'b1; k++) tick(1'b0, 8'h00, 1'b0);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rnd_timeout got=%b exp=0", busy); end
    checks++; if (rx_q.size() != m_acc.size()) begin failures++; $display("[TB] FAIL rnd_rx_n got=%0d exp=%0d", rx_q.size(), m_acc.size()); end
    for (int i = 0; i < rx_q.size() && i < m_acc.size(); i++) begin
      checks++; if (rx_q[i] !== m_acc[i]) begin failures++; $display("[TB] FAIL rnd_rx[%0d] got=%h exp=%h", i, rx_q[i], m_acc[i]); end
    end
    checks++; if (rx_err != 0) begin failures++; $display("[TB] FAIL stop_bits got=%0d bad exp=0", rx_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
